// File: rtl/button_pkg.sv
// Shared types and constants for the push-button front end of the lock chip.
package button_pkg;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_ENTER0  = 3'd1,
    EV_ENTER1  = 3'd2,
    EV_CONFIRM = 3'd3,
    EV_CLEAR   = 3'd4,
    EV_SELECT  = 3'd5
  } event_t;

  localparam int NUM_BUTTONS = 5;

  // Bit positions of each button inside the conditioned press/stable vectors.
  localparam int BTN_ENTER0  = 0;
  localparam int BTN_ENTER1  = 1;
  localparam int BTN_CONFIRM = 2;
  localparam int BTN_CLEAR   = 3;
  localparam int BTN_SELECT  = 4;

endpackage

// File: rtl/button_debouncer.sv
// One button channel: synchroniser, level debouncer and registered rising-edge pulse.
module button_debouncer #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic stable,
  output logic press
);

  // Count value on which a mismatching level has persisted long enough to accept.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   synced;
  logic [CNT_W-1:0]       cnt;
  logic                   stable_d;

  assign synced = sync_p0[SYNC_STAGES-1];

  // Shift the asynchronous button through the synchroniser chain.
  always_ff @(posedge clock) begin
    if (!reset) begin
      sync_p0 <= '0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], raw};
    end
  end

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt    <= '0;
      stable <= 1'b0;
    end else if (synced == stable) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      stable <= synced;
      cnt    <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // One-cycle pulse on each accepted 0->1 transition; releases produce nothing.
  always_ff @(posedge clock) begin
    if (!reset) begin
      stable_d <= 1'b0;
      press    <= 1'b0;
    end else begin
      stable_d <= stable;
      press    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/button_event_encoder.sv
// Conditions the five raw buttons, picks one winner per cycle by priority and
// holds it in a one-entry valid/ready buffer for the lock/mode FSM.
module button_event_encoder
  import button_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 2,
  parameter int CNT_W           = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enter0,
  input  logic       enter1,
  input  logic       confirm,
  input  logic       clear,
  input  logic       algorithm_select_mode,
  input  logic       event_ready,
  output logic       event_valid,
  output logic [2:0] event_code,
  output logic       event_dropped,
  output logic       buttons_idle
);

  logic [NUM_BUTTONS-1:0] raw_vec;
  logic [NUM_BUTTONS-1:0] stable_vec;
  logic [NUM_BUTTONS-1:0] press_vec;
  event_t                 winner;
  event_t                 code_q;

  assign raw_vec[BTN_ENTER0]  = enter0;
  assign raw_vec[BTN_ENTER1]  = enter1;
  assign raw_vec[BTN_CONFIRM] = confirm;
  assign raw_vec[BTN_CLEAR]   = clear;
  assign raw_vec[BTN_SELECT]  = algorithm_select_mode;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
      button_debouncer #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
      ) u_deb (
        .clock (clock),
        .reset (reset),
        .raw   (raw_vec[gi]),
        .stable(stable_vec[gi]),
        .press (press_vec[gi])
      );
    end
  endgenerate

  // Priority encode simultaneous presses: clear > confirm > select > enter1 > enter0.
  always_comb begin
    winner = EV_NONE;
    if (press_vec[BTN_CLEAR])        winner = EV_CLEAR;
    else if (press_vec[BTN_CONFIRM]) winner = EV_CONFIRM;
    else if (press_vec[BTN_SELECT])  winner = EV_SELECT;
    else if (press_vec[BTN_ENTER1])  winner = EV_ENTER1;
    else if (press_vec[BTN_ENTER0])  winner = EV_ENTER0;
  end

  // One-entry buffer: load when empty or being consumed, otherwise discard and flag the drop.
  always_ff @(posedge clock) begin
    if (!reset) begin
      event_valid   <= 1'b0;
      code_q        <= EV_NONE;
      event_dropped <= 1'b0;
      buttons_idle  <= 1'b1;
    end else begin
      buttons_idle  <= ~|stable_vec;
      event_dropped <= 1'b0;
      if (|press_vec) begin
        if (!event_valid || event_ready) begin
          event_valid <= 1'b1;
          code_q      <= winner;
        end else begin
          event_dropped <= 1'b1;
        end
      end else if (event_valid && event_ready) begin
        event_valid <= 1'b0;
        code_q      <= EV_NONE;
      end
    end
  end

  assign event_code = code_q;

endmodule

// File: tb/tb_button_event_encoder.sv
// Scoreboard bench for button_event_encoder: each press pushes its expected code
// and arrival cycle; a negedge monitor pops and compares as events appear.
module tb_button_event_encoder;
  import button_pkg::*;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] raw = '0;
  logic       event_ready = 1'b0;
  logic       event_valid;
  logic [2:0] event_code;
  logic       event_dropped;
  logic       buttons_idle;

  typedef struct {
    logic [2:0] code;
    int         cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   drop_cnt = 0;
  logic prev_valid = 1'b0;
  logic prev_consumed = 1'b0;

  button_event_encoder dut (
    .clock                (clock),
    .reset                (reset),
    .enter0               (raw[BTN_ENTER0]),
    .enter1               (raw[BTN_ENTER1]),
    .confirm              (raw[BTN_CONFIRM]),
    .clear                (raw[BTN_CLEAR]),
    .algorithm_select_mode(raw[BTN_SELECT]),
    .event_ready          (event_ready),
    .event_valid          (event_valid),
    .event_code           (event_code),
    .event_dropped        (event_dropped),
    .buttons_idle         (buttons_idle)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // Event monitor: a new event is valid with an empty or just-consumed buffer before it.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      if (event_valid && (!prev_valid || prev_consumed)) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event code=%0d cycle=%0d required=no event", event_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (event_code !== e.code || cyc != e.cyc) begin
            errors++;
            $display("FAIL event code=%0d cycle=%0d required code=%0d cycle=%0d",
                     event_code, cyc, e.code, e.cyc);
          end
        end
      end
      if (event_dropped === 1'b1) drop_cnt++;
    end
    prev_valid    = event_valid;
    prev_consumed = event_valid && event_ready;
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_event(input logic [2:0] code);
    exp_t e;
    e.code = code;
    e.cyc  = cyc + 6;
    exp_q.push_back(e);
  endtask

  task automatic press_btn(input int idx, input int on_cycles, input int off_cycles);
    raw[idx] = 1'b1;
    repeat (on_cycles) step();
    raw[idx] = 1'b0;
    repeat (off_cycles) step();
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() > 0; i++) step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_timeout pending=%0d required=0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (8) step();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    raw = '0;
    event_ready = 1'b0;
    repeat (3) step();
    checks++;
    if (event_valid !== 1'b0 || event_code !== 3'd0 || event_dropped !== 1'b0 || buttons_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_state valid=%b code=%0d dropped=%b idle=%b required 0 0 0 1",
               event_valid, event_code, event_dropped, buttons_idle);
    end
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      checks++;
      if (event_valid !== 1'b0 || event_code !== 3'd0 || buttons_idle !== 1'b1) begin
        errors++;
        $display("FAIL idle_cycle%0d valid=%b code=%0d idle=%b required 0 0 1",
                 i, event_valid, event_code, buttons_idle);
      end
    end
    step();
  endtask

  task automatic test_single_press();
    int d0;
    event_ready = 1'b1;
    d0 = drop_cnt;
    expect_event(EV_ENTER1);
    press_btn(BTN_ENTER1, 3, 3);
    wait_drain("single_press");
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL single_press_drops got=%0d required=0", drop_cnt - d0);
    end
  endtask

  task automatic test_sequence();
    logic [5:0] pattern;
    int d0;
    pattern = 6'b101101;
    d0 = drop_cnt;
    event_ready = 1'b1;
    for (int i = 5; i >= 0; i--) begin
      if (pattern[i]) begin
        expect_event(EV_ENTER1);
        press_btn(BTN_ENTER1, 3, 3);
      end else begin
        expect_event(EV_ENTER0);
        press_btn(BTN_ENTER0, 3, 3);
      end
    end
    expect_event(EV_CONFIRM);
    press_btn(BTN_CONFIRM, 3, 3);
    wait_drain("sequence");
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL sequence_drops got=%0d required=0", drop_cnt - d0);
    end
  endtask

  task automatic test_glitch();
    event_ready = 1'b1;
    raw[BTN_CLEAR] = 1'b1;
    step();
    raw[BTN_CLEAR] = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (buttons_idle !== 1'b1 || event_valid !== 1'b0) begin
        errors++;
        $display("FAIL glitch_cycle%0d idle=%b valid=%b required idle=1 valid=0", i, buttons_idle, event_valid);
      end
    end
    step();
    expect_event(EV_CLEAR);
    press_btn(BTN_CLEAR, 2, 4);
    wait_drain("clear_press");
  endtask

  task automatic test_backpressure();
    int d0;
    event_ready = 1'b0;
    expect_event(EV_ENTER0);
    press_btn(BTN_ENTER0, 3, 3);
    wait_drain("held_event");
    d0 = drop_cnt;
    press_btn(BTN_CONFIRM, 3, 8);
    checks++;
    if (drop_cnt - d0 != 1) begin
      errors++;
      $display("FAIL drop_pulses got=%0d required=1", drop_cnt - d0);
    end
    checks++;
    if (event_valid !== 1'b1 || event_code !== EV_ENTER0) begin
      errors++;
      $display("FAIL held_after_drop valid=%b code=%0d required valid=1 code=%0d", event_valid, event_code, EV_ENTER0);
    end
    event_ready = 1'b1;
    step();
    event_ready = 1'b0;
    @(negedge clock);
    checks++;
    if (event_valid !== 1'b0 || event_code !== 3'd0) begin
      errors++;
      $display("FAIL consume valid=%b code=%0d required valid=0 code=0", event_valid, event_code);
    end
    step();
    event_ready = 1'b1;
  endtask

  task automatic test_simultaneous_and_reset();
    int d0;
    event_ready = 1'b1;
    d0 = drop_cnt;
    expect_event(EV_CONFIRM);
    raw[BTN_CONFIRM] = 1'b1;
    raw[BTN_ENTER0]  = 1'b1;
    repeat (3) step();
    raw[BTN_CONFIRM] = 1'b0;
    raw[BTN_ENTER0]  = 1'b0;
    repeat (3) step();
    wait_drain("simultaneous");
    checks++;
    if (drop_cnt != d0) begin
      errors++;
      $display("FAIL simultaneous_drops got=%0d required=0", drop_cnt - d0);
    end
    // Hold enter1 with backpressure so its event sits in the buffer when reset hits.
    event_ready = 1'b0;
    expect_event(EV_ENTER1);
    raw[BTN_ENTER1] = 1'b1;
    repeat (8) step();
    checks++;
    if (event_valid !== 1'b1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL pre_reset_buffer valid=%b pending=%0d required valid=1 pending=0", event_valid, exp_q.size());
      exp_q.delete();
    end
    reset = 1'b0;
    step();
    checks++;
    if (event_valid !== 1'b0 || event_code !== 3'd0 || buttons_idle !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset valid=%b code=%0d idle=%b required 0 0 1", event_valid, event_code, buttons_idle);
    end
    reset = 1'b1;
    expect_event(EV_ENTER1);
    event_ready = 1'b1;
    wait_drain("reset_repress");
    raw[BTN_ENTER1] = 1'b0;
    repeat (6) step();
    checks++;
    if (buttons_idle !== 1'b1 || event_valid !== 1'b0) begin
      errors++;
      $display("FAIL final_idle idle=%b valid=%b required idle=1 valid=0", buttons_idle, event_valid);
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_sequence();
    test_glitch();
    test_backpressure();
    test_simultaneous_and_reset();
    repeat (4) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
